// File: rtl/prog_table_fsm_if.sv
// Table configuration port of prog_table_fsm: write/read strobes, address, data and error pulse.
interface prog_table_fsm_if #(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned ST_W  = 3,
   parameter int unsigned OUT_W = 3
);
   localparam int unsigned A_W = IN_W + ST_W;
   localparam int unsigned E_W = ST_W + OUT_W;

   logic           cfg_we;
   logic           cfg_re;
   logic [A_W-1:0] cfg_addr;
   logic [E_W-1:0] cfg_wdata;
   logic [E_W-1:0] cfg_rdata;
   logic           cfg_err;

   modport master (
      output cfg_we, cfg_re, cfg_addr, cfg_wdata,
      input  cfg_rdata, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
      output cfg_rdata, cfg_err
   );
endinterface

// File: rtl/prog_table_fsm.sv
// Table-driven Moore FSM engine: transition RAM loaded via cfg port, run/step control,
// saturating transition counter and stuck detection.
module prog_table_fsm #(
   parameter int unsigned IN_W      = 2,
   parameter int unsigned ST_W      = 3,
   parameter int unsigned OUT_W     = 3,
   parameter int unsigned RST_STATE = 0,
   parameter int unsigned RST_OUT   = 0,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned STUCK_N   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               run,
   input  logic               step,
   input  logic [IN_W-1:0]    in_sym,
   output logic [ST_W-1:0]    state,
   output logic [OUT_W-1:0]   out_sym,
   output logic [CNT_W-1:0]   trans_cnt,
   output logic               stuck,
   prog_table_fsm_if.slave    cfg
);
   localparam int unsigned A_W   = IN_W + ST_W;
   localparam int unsigned E_W   = ST_W + OUT_W;
   localparam int unsigned DEPTH = 1 << A_W;
   localparam int unsigned RL_W  = $clog2(STUCK_N + 1);

   logic [E_W-1:0]   tbl_q [DEPTH];

   logic [ST_W-1:0]  state_q, state_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RL_W-1:0]  rl_q, rl_d;
   logic             stuck_q, stuck_d;
   logic [E_W-1:0]   rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             adv_c;
   logic             cfg_wr_c;
   logic [E_W-1:0]   entry_c;
   logic [ST_W-1:0]  nxt_st_c;

   // Next-state, counter, stuck and config-port logic
   always_comb begin
      adv_c    = run | (step & ~run);
      entry_c  = tbl_q[{in_sym, state_q}];
      nxt_st_c = entry_c[E_W-1:OUT_W];
      state_d  = state_q;
      out_d    = out_q;
      cnt_d    = cnt_q;
      rl_d     = rl_q;
      stuck_d  = stuck_q;

      if (clr) begin
         state_d = ST_W'(RST_STATE);
         out_d   = OUT_W'(RST_OUT);
         cnt_d   = '0;
         rl_d    = '0;
         stuck_d = 1'b0;
      end else if (adv_c) begin
         state_d = nxt_st_c;
         out_d   = entry_c[OUT_W-1:0];
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         // Run-length saturates at STUCK_N so stuck stays set until a changing advance
         if (nxt_st_c == state_q) begin
            if (rl_q < RL_W'(STUCK_N)) rl_d = rl_q + RL_W'(1);
         end else begin
            rl_d = '0;
         end
         stuck_d = (rl_d == RL_W'(STUCK_N));
      end

      cfg_wr_c = cfg.cfg_we & ~run & ~step;
      err_d    = cfg.cfg_we & (run | step);
      rdata_d  = cfg.cfg_re ? tbl_q[cfg.cfg_addr] : rdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_W'(RST_STATE);
         out_q   <= OUT_W'(RST_OUT);
         cnt_q   <= '0;
         rl_q    <= '0;
         stuck_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         rl_q    <= rl_d;
         stuck_q <= stuck_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Transition RAM is never reset; contents survive reset and clr
   always_ff @(posedge clk) begin
      if (cfg_wr_c) tbl_q[cfg.cfg_addr] <= cfg.cfg_wdata;
   end

   assign state         = state_q;
   assign out_sym       = out_q;
   assign trans_cnt     = cnt_q;
   assign stuck         = stuck_q;
   assign cfg.cfg_rdata = rdata_q;
   assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_prog_table_fsm.sv
// Directed bench for prog_table_fsm: default instance plus a CNT_W=3 instance on shared stimulus.
module tb_prog_table_fsm;
   logic       clk = 1'b0;
   logic       reset;
   logic       clr, run, step;
   logic [1:0] in_sym;
   logic [2:0] state, state3;
   logic [2:0] out_sym, out_sym3;
   logic [7:0] trans_cnt;
   logic [2:0] trans_cnt3;
   logic       stuck, stuck3;
   logic [5:0] rd;

   int n_vec = 0;
   int n_err = 0;

   prog_table_fsm_if #(.IN_W(2), .ST_W(3), .OUT_W(3)) u_if  ();
   prog_table_fsm_if #(.IN_W(2), .ST_W(3), .OUT_W(3)) u_if3 ();

   assign u_if3.cfg_we    = u_if.cfg_we;
   assign u_if3.cfg_re    = u_if.cfg_re;
   assign u_if3.cfg_addr  = u_if.cfg_addr;
   assign u_if3.cfg_wdata = u_if.cfg_wdata;

   prog_table_fsm u_dut (
      .clk(clk), .reset(reset), .clr(clr), .run(run), .step(step), .in_sym(in_sym),
      .state(state), .out_sym(out_sym), .trans_cnt(trans_cnt), .stuck(stuck), .cfg(u_if)
   );

   prog_table_fsm #(.CNT_W(3)) u_dut3 (
      .clk(clk), .reset(reset), .clr(clr), .run(run), .step(step), .in_sym(in_sym),
      .state(state3), .out_sym(out_sym3), .trans_cnt(trans_cnt3), .stuck(stuck3), .cfg(u_if3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [5:0] d);
      u_if.cfg_we = 1'b1; u_if.cfg_addr = a; u_if.cfg_wdata = d;
      tick();
      u_if.cfg_we = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [5:0] d);
      u_if.cfg_re = 1'b1; u_if.cfg_addr = a;
      tick();
      u_if.cfg_re = 1'b0;
      d = u_if.cfg_rdata;
   endtask

   task automatic step_pulse();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   initial begin
      reset = 1'b0; clr = 1'b0; run = 1'b0; step = 1'b0; in_sym = 2'd0;
      u_if.cfg_we = 1'b0; u_if.cfg_re = 1'b0; u_if.cfg_addr = '0; u_if.cfg_wdata = '0;
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_out", 32'(out_sym), 32'd0);
      check("rst_cnt", 32'(trans_cnt), 32'd0);
      check("rst_stuck", 32'(stuck), 32'd0);
      check("rst_rdata", 32'(u_if.cfg_rdata), 32'd0);
      check("rst_err", 32'(u_if.cfg_err), 32'd0);
      reset = 1'b1;
      tick();

      // Table: {0,0}->{1,1} {0,1}->{2,2} {0,2}->{0,0} {1,0}->{5,5} {3,5}->{5,5} {0,5}->{0,0}
      cfg_write(5'd0, 6'd9);
      check("wr_noerr", 32'(u_if.cfg_err), 32'd0);
      cfg_write(5'd1, 6'd18);
      cfg_write(5'd2, 6'd0);
      cfg_write(5'd8, 6'd45);
      cfg_write(5'd29, 6'd45);
      cfg_write(5'd5, 6'd0);
      cfg_read(5'd1, rd);
      check("rd_t1", 32'(rd), 32'd18);

      // Free run through 0->1->2->0->1
      run = 1'b1;
      tick(); check("run1_st", 32'(state), 32'd1); check("run1_out", 32'(out_sym), 32'd1);
      tick(); check("run2_st", 32'(state), 32'd2); check("run2_out", 32'(out_sym), 32'd2);
      tick(); check("run3_st", 32'(state), 32'd0); check("run3_out", 32'(out_sym), 32'd0);
      tick(); check("run4_st", 32'(state), 32'd1); check("run4_out", 32'(out_sym), 32'd1);
      run = 1'b0;
      check("run_cnt", 32'(trans_cnt), 32'd4);

      // clr wins over a simultaneous advance
      clr = 1'b1; run = 1'b1;
      tick();
      clr = 1'b0; run = 1'b0;
      check("clr_st", 32'(state), 32'd0);
      check("clr_cnt", 32'(trans_cnt), 32'd0);
      cfg_read(5'd1, rd);
      check("clr_tbl", 32'(rd), 32'd18);

      // Single steps with idle gaps
      step_pulse(); check("stp1_st", 32'(state), 32'd1);
      tick();       check("stp_hold", 32'(state), 32'd1);
      step_pulse(); check("stp2_st", 32'(state), 32'd2);
      tick();
      step_pulse(); check("stp3_st", 32'(state), 32'd0);
      tick();       check("stp_cnt", 32'(trans_cnt), 32'd3);

      // Stuck: enter state 5, self-loop four times, then leave
      in_sym = 2'd1;
      step_pulse();
      check("stk_enter", 32'(state), 32'd5);
      check("stk_out", 32'(out_sym), 32'd5);
      in_sym = 2'd3; run = 1'b1;
      tick(); tick(); tick();
      check("stk_3rd", 32'(stuck), 32'd0);
      tick();
      check("stk_4th", 32'(stuck), 32'd1);
      check("stk_st", 32'(state), 32'd5);
      run = 1'b0;
      tick();
      check("stk_idle", 32'(stuck), 32'd1);
      in_sym = 2'd0;
      step_pulse();
      check("stk_clear", 32'(stuck), 32'd0);
      check("stk_leave", 32'(state), 32'd0);
      check("cnt8_9", 32'(trans_cnt), 32'd9);
      check("cnt3_sat", 32'(trans_cnt3), 32'd7);

      // Write during run is dropped with a 1-clk error pulse
      run = 1'b1; u_if.cfg_we = 1'b1; u_if.cfg_addr = 5'd0; u_if.cfg_wdata = 6'd63;
      tick();
      u_if.cfg_we = 1'b0;
      check("drop_err", 32'(u_if.cfg_err), 32'd1);
      check("drop_adv", 32'(state), 32'd1);
      tick();
      check("drop_err_off", 32'(u_if.cfg_err), 32'd0);
      run = 1'b0;
      cfg_read(5'd0, rd);
      check("drop_tbl", 32'(rd), 32'd9);
      cfg_write(5'd6, 6'd12);
      check("idle_wr_err", 32'(u_if.cfg_err), 32'd0);

      // Simultaneous write+read returns old data
      u_if.cfg_we = 1'b1; u_if.cfg_re = 1'b1; u_if.cfg_addr = 5'd6; u_if.cfg_wdata = 6'd33;
      tick();
      u_if.cfg_we = 1'b0; u_if.cfg_re = 1'b0;
      check("rw_old", 32'(u_if.cfg_rdata), 32'd12);
      tick();
      check("rd_hold", 32'(u_if.cfg_rdata), 32'd12);
      cfg_read(5'd6, rd);
      check("rw_new", 32'(rd), 32'd33);

      // Asynchronous reset mid-cycle
      run = 1'b1;
      tick();
      #3 reset = 1'b0;
      #1;
      check("arst_st", 32'(state), 32'd0);
      check("arst_out", 32'(out_sym), 32'd0);
      check("arst_cnt", 32'(trans_cnt), 32'd0);
      run = 1'b0;
      #1 reset = 1'b1;
      cfg_read(5'd0, rd);
      check("arst_tbl", 32'(rd), 32'd9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
